// File: rtl/smm_pkg.sv
// ---------------------------------------------------------------------------
// smm_pkg
// Shared constants and the response record of the sparse-matrix-power
// multiplier arbiter.
//   SMM_DATA_W       : operand/result width of the shared multiplier (32)
//   SMM_NREQ_DEFAULT : default number of requesters (4)
//   SMM_ID_W_MAX     : tag width able to hold any legal requester index (<= 8)
//   smm_rsp_t        : {valid, id, data} view of one response beat
// ---------------------------------------------------------------------------
package smm_pkg;

   localparam int SMM_DATA_W       = 32;
   localparam int SMM_NREQ_DEFAULT = 4;
   localparam int SMM_ID_W_MAX     = 3;

   typedef struct packed {
      logic                    valid;
      logic [SMM_ID_W_MAX-1:0] id;
      logic [SMM_DATA_W-1:0]   data;
   } smm_rsp_t;

endpackage

// File: rtl/smm_mul_32s_32s_32_2_1.sv
// ---------------------------------------------------------------------------
// smm_mul_32s_32s_32_2_1
// Pipelined signed multiplier, low dout_WIDTH bits of din0*din1. NUM_STAGE
// counts the input as stage 0, so NUM_STAGE=2 gives one registered stage.
// The product registers carry no reset; consumers qualify dout with their own
// valid.
// Ports:
//   clk  : clock, rising edge
//   ce   : clock enable, freezes every product register when low
//   din0 : signed operand A
//   din1 : signed operand B
//   dout : truncated two's-complement product, NUM_STAGE-1 cycles later
// ---------------------------------------------------------------------------
module smm_mul_32s_32s_32_2_1
   import smm_pkg::*;
#(
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = SMM_DATA_W,
   parameter int din1_WIDTH = SMM_DATA_W,
   parameter int dout_WIDTH = SMM_DATA_W
) (
   input  logic                          clk,
   input  logic                          ce,
   input  logic signed [din0_WIDTH-1:0]  din0,
   input  logic signed [din1_WIDTH-1:0]  din1,
   output logic signed [dout_WIDTH-1:0]  dout
);

   localparam int DEPTH = NUM_STAGE - 1;

   // Wrapping product: upper bits are dropped, overflow is not flagged.
   function automatic logic signed [dout_WIDTH-1:0] trunc_prod(
      input logic signed [din0_WIDTH-1:0] x,
      input logic signed [din1_WIDTH-1:0] y
   );
      return x * y;
   endfunction

   logic signed [dout_WIDTH-1:0] prod_p0;
   logic signed [dout_WIDTH-1:0] pipe_p [DEPTH];

   assign prod_p0 = trunc_prod(din0, din1);

   // ---- stage p0 -> p1 .. pDEPTH ----
   always_ff @(posedge clk) begin
      if (ce) begin
         pipe_p[0] <= prod_p0;
         for (int k = 1; k < DEPTH; k++) begin
            pipe_p[k] <= pipe_p[k-1];
         end
      end
   end

   assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/smm_mul_arbiter.sv
// ---------------------------------------------------------------------------
// smm_mul_arbiter
// Round-robin sharing of one pipelined signed multiplier among NREQ
// requesters. One request is accepted per cycle; the product returns one
// cycle later on a single tagged response channel with backpressure.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous reset, active low
//   req_valid : per-requester operand valid
//   req_ready : per-requester accept, one-hot or zero
//   req_a     : operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b     : operand B, same packing
//   rsp_valid : result valid
//   rsp_ready : downstream accept
//   rsp_id    : requester index of the result
//   rsp_data  : low DATA_W bits of signed a*b, zero when rsp_valid is low
//   issue_cnt : number of accepted requests, wraps
// ---------------------------------------------------------------------------
module smm_mul_arbiter
   import smm_pkg::*;
#(
   parameter int NREQ   = SMM_NREQ_DEFAULT,
   parameter int DATA_W = SMM_DATA_W,
   parameter int ID_W   = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_a,
   input  logic [NREQ*DATA_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [DATA_W-1:0]      rsp_data,
   output logic [31:0]            issue_cnt
);

   // First valid requester at or after p, wrapping; returns {hit, index}.
   function automatic logic [ID_W:0] rr_pick(
      input logic [NREQ-1:0] v,
      input logic [ID_W-1:0] p
   );
      logic            hit;
      logic [ID_W-1:0] sel;
      int              j;
      hit = 1'b0;
      sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(p) + k) % NREQ;
         if (!hit && v[j]) begin
            hit = 1'b1;
            sel = ID_W'(j);
         end
      end
      return {hit, sel};
   endfunction

   logic [ID_W-1:0]           ptr;
   logic [ID_W-1:0]           ptr_nxt;
   logic [ID_W-1:0]           g_p0;
   logic                      hit_p0;
   logic                      stall;
   logic                      ce;
   logic                      xfer_p0;
   logic signed [DATA_W-1:0]  a_p0;
   logic signed [DATA_W-1:0]  b_p0;
   logic signed [DATA_W-1:0]  prod_p1;
   logic                      vld_p1;
   logic [ID_W-1:0]           tag_id_p1;

   // ---- stage p0: arbitration and operand select ----
   always_comb begin
      {hit_p0, g_p0} = rr_pick(req_valid, ptr);
      stall     = vld_p1 & ~rsp_ready;
      ce        = ~stall;
      // reset gates the grant so req_ready is low for the whole reset window
      xfer_p0   = hit_p0 & ce & reset;
      ptr_nxt   = (g_p0 == ID_W'(NREQ-1)) ? '0 : g_p0 + ID_W'(1);
      req_ready = '0;
      if (xfer_p0) begin
         req_ready[g_p0] = 1'b1;
      end
      a_p0 = '0;
      b_p0 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (g_p0 == ID_W'(i)) begin
            a_p0 = req_a[i*DATA_W +: DATA_W];
            b_p0 = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   // ---- stage p0 -> p1: tag shadows the multiplier product register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         vld_p1    <= 1'b0;
         tag_id_p1 <= '0;
         issue_cnt <= '0;
      end else begin
         if (ce) begin
            vld_p1    <= xfer_p0;
            tag_id_p1 <= g_p0;
         end
         if (xfer_p0) begin
            ptr       <= ptr_nxt;
            issue_cnt <= issue_cnt + 32'd1;
         end
      end
   end

   smm_mul_32s_32s_32_2_1 #(
      .NUM_STAGE  (2),
      .din0_WIDTH (DATA_W),
      .din1_WIDTH (DATA_W),
      .dout_WIDTH (DATA_W)
   ) u_mul (
      .clk  (clk),
      .ce   (ce),
      .din0 (a_p0),
      .din1 (b_p0),
      .dout (prod_p1)
   );

   // ---- stage p1: response ----
   // The product register is never reset, so the data is masked by valid.
   assign rsp_valid = vld_p1;
   assign rsp_id    = tag_id_p1;
   assign rsp_data  = prod_p1 & {DATA_W{vld_p1}};

endmodule

// File: tb/tb_smm_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_smm_mul_arbiter
// Directed and random stimulus for smm_mul_arbiter (NREQ=4), compared every
// cycle against a transaction-level reference: round-robin grant search,
// one pending response slot, 64-bit integer product truncated to 32 bits.
// ---------------------------------------------------------------------------
module tb_smm_mul_arbiter;
   import smm_pkg::*;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int IW   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;
   logic [31:0]       issue_cnt;

   smm_mul_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ID_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;

   // reference state
   int          mptr;
   bit          mvld;
   int          mid;
   logic [31:0] mdata;
   logic [31:0] mcnt;
   int          exp_g;
   int          grants[$];
   smm_rsp_t    obs;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return 32'(p);
   endfunction

   function automatic logic [31:0] opa(input int i);
      return req_a[i*DW +: DW];
   endfunction

   function automatic logic [31:0] opb(input int i);
      return req_b[i*DW +: DW];
   endfunction

   // Requester that should be granted now, or -1.
   function automatic int pick();
      int j;
      if (reset !== 1'b1) return -1;
      if (mvld && rsp_ready !== 1'b1) return -1;
      for (int k = 0; k < NREQ; k++) begin
         j = (mptr + k) % NREQ;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   task automatic model_reset();
      mvld = 1'b0;
      mid  = 0;
      mcnt = 32'd0;
      mptr = 0;
   endtask

   task automatic check_all();
      logic [NREQ-1:0] er;
      er = (exp_g < 0) ? '0 : NREQ'(1 << exp_g);
      obs = '{valid: rsp_valid, id: SMM_ID_W_MAX'(rsp_id), data: rsp_data};
      chk("req_ready", req_ready, er);
      chk("rsp_valid", obs.valid, mvld);
      if (mvld) chk("rsp_id", obs.id, mid);
      chk("rsp_data", obs.data, mvld ? mdata : 32'd0);
      chk("issue_cnt", issue_cnt, mcnt);
   endtask

   task automatic update(input int g);
      if (reset !== 1'b1) begin
         model_reset();
      end else if (!(mvld && rsp_ready !== 1'b1)) begin
         if (g >= 0) begin
            mvld  = 1'b1;
            mid   = g;
            mdata = prod(opa(g), opb(g));
            mptr  = (g + 1) % NREQ;
            mcnt  = mcnt + 32'd1;
            grants.push_back(g);
         end else begin
            mvld = 1'b0;
         end
      end
   endtask

   // Inputs are held from just after one rising edge to just after the next.
   task automatic cycle();
      @(negedge clk);
      exp_g = pick();
      check_all();
      @(posedge clk);
      update(exp_g);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      model_reset();
      mdata = '0;

      // reset asserted with requests pending: nothing may be granted
      req_valid = 4'hF;
      cycle();
      cycle();
      chk("rst_id", rsp_id, 0);
      chk("rst_ready", req_ready, 0);
      reset     = 1'b1;
      req_valid = '0;
      cycle();

      // single request: requester 1, -3 * 7
      set_op(1, 32'hFFFF_FFFD, 32'd7);
      req_valid = 4'b0010;
      cycle();
      req_valid = '0;
      chk("single_vld", rsp_valid, 1);
      chk("single_id", rsp_id, 1);
      chk("single_data", rsp_data, 32'hFFFF_FFEB);
      chk("single_cnt", issue_cnt, 1);
      cycle();

      // wrapping products
      set_op(2, 32'h7FFF_FFFF, 32'd2);
      req_valid = 4'b0100;
      cycle();
      req_valid = '0;
      chk("wrap_pos", rsp_data, 32'hFFFF_FFFE);
      set_op(3, 32'h8000_0000, 32'hFFFF_FFFF);
      req_valid = 4'b1000;
      cycle();
      req_valid = '0;
      chk("wrap_neg", rsp_data, 32'h8000_0000);
      cycle();

      // reset one cycle after a transfer: in-flight result is discarded
      set_op(0, $urandom, $urandom);
      req_valid = 4'b0001;
      cycle();
      req_valid = '0;
      chk("mid_inflight", rsp_valid, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_vld", rsp_valid, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_cnt", issue_cnt, 0);
      model_reset();
      cycle();
      cycle();
      reset = 1'b1;
      repeat (3) cycle();

      // fairness: all four hold valid for 8 cycles, starting from ptr=0
      grants.delete();
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
      req_valid = 4'hF;
      repeat (8) cycle();
      req_valid = '0;
      chk("fair_n", grants.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < grants.size()) chk("fair_grant", grants[k], k % NREQ);
      end
      chk("fair_cnt", issue_cnt, 8);
      cycle();

      // backpressure: result pending while downstream stalls for 3 cycles
      set_op(1, $urandom, $urandom);
      req_valid = 4'b0010;
      cycle();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
      repeat (3) cycle();
      rsp_ready = 1'b1;
      repeat (4) cycle();
      req_valid = '0;
      cycle();

      // sparse requests
      grants.delete();
      req_valid = 4'b0100;
      cycle();
      req_valid = 4'b1001;
      cycle();
      cycle();
      req_valid = '0;
      cycle();
      chk("sparse_n", grants.size(), 3);
      if (grants.size() == 3) begin
         chk("sparse_g0", grants[0], 2);
         chk("sparse_g1", grants[1], 3);
         chk("sparse_g2", grants[2], 0);
      end

      // random traffic with random backpressure
      repeat (400) begin
         req_valid = NREQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
         cycle();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/smm_mul_arbiter.md
# smm_mul_arbiter

Shares one pipelined 32×32 signed multiplier (`smm_mul_32s_32s_32_2_1`, one registered stage, `ce`-gated) among NREQ requesters in the sparse-matrix-power datapath. Arbitration is round-robin with a valid/ready handshake per requester. Each product is returned on one tagged response channel with backpressure. The block sits between the row-partial-product generators and the accumulation stage.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: operand and result width; fixed at 32 to match the multiplier.
- `ID_W`, $clog2(NREQ): width of the requester tag.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset, asynchronous assert, active-low (asserted when 0). Synchronous deassert is the integrator's responsibility.
- `req_valid` in NREQ: per-requester operand valid.
- `req_ready` out NREQ: per-requester accept; at most one bit is high.
- `req_a` in NREQ*DATA_W: operand A; requester i occupies bits [i*32 +: 32].
- `req_b` in NREQ*DATA_W: operand B, same packing as `req_a`.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: downstream accept.
- `rsp_id` out ID_W: index of the requester that issued the result.
- `rsp_data` out DATA_W: low 32 bits of signed a*b.
- `issue_cnt` out 32: total accepted requests; wraps modulo 2^32.

## Operation
- **Stall signal.** `stall = rsp_valid & ~rsp_ready`, and `ce = ~stall`. The `ce` signal drives the multiplier and all tag/valid registers.
- **Round-robin pointer.** `ptr` (ID_W bits) resets to 0.
- **Grant selection.** Grant g is the first i in ptr, ptr+1, …, NREQ-1, 0, … with `req_valid[i]=1`. A grant is given only when `ce=1`.
- **Ready.** `req_ready[g]=1`, combinational from `req_valid` and `stall`. Requesters must not make `valid` depend on `ready`.
- **Transfer.** A transfer happens when `req_valid[g] & req_ready[g]` at a clock edge. On a transfer, `ptr <= (g+1) mod NREQ`. With no transfer, `ptr` holds.
- **Operand mux.** Multiplier operands are `req_a`/`req_b` of g. When there is no grant, the operands are don't-care.
- **Tag register.** `tag_valid <= transfer`, `tag_id <= g`, loaded only when `ce=1`. It shadows the multiplier's product register.
- **Response.** `rsp_valid = tag_valid` and `rsp_id = tag_id`.
- **Masked data.** `rsp_data` = multiplier output AND-masked with `rsp_valid`. It is 0 whenever `rsp_valid=0`, because the multiplier register has no reset.
- **Arithmetic.** Two's-complement product truncated to 32 bits. Overflow wraps and is not flagged.
- **Issue counter.** `issue_cnt` increments by 1 per transfer.
- **Reset values.** `req_ready=0` while reset is asserted. `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `issue_cnt=0`, `ptr=0`.
- **Reset mid-operation.** An in-flight product is discarded and `tag_valid` clears asynchronously. No response is emitted for it after reset.

## Timing
- **Latency.** Accept at edge t; `rsp_valid`/`rsp_data` are valid after edge t, i.e. in cycle t+1.
- **Throughput.** One request per cycle while `rsp_ready=1`.
- **Back-to-back.** A new transfer can complete in the same cycle the previous result is taken: `rsp_ready=1` forces `ce=1`.
- **Stall.** While stalled, `rsp_*` hold stable, all `req_ready=0`, and `ptr`, `issue_cnt` and the multiplier register freeze.
- **Simultaneous requests.** Exactly one grant per cycle. Losers keep `valid` and operands stable and are served within NREQ-1 grants.
- **Single requester.** Continuous `valid` from one requester with no others gives one grant per cycle.

## Structure
- Package `smm_pkg`: `SMM_DATA_W=32`, `SMM_NREQ_DEFAULT=4`, and the `smm_rsp_t` struct {valid, id, data}.
- One sub-module: `smm_mul_32s_32s_32_2_1`, instantiated with NUM_STAGE=2, din0/din1/dout widths 32, `ce` tied to `~stall`.
- Round-robin selection is a combinational function in the top module; no separate arbiter module.

## Test plan
- **Single request.** Requester 1 sends a=-3, b=7 → one cycle later `rsp_valid=1`, `rsp_id=1`, `rsp_data=0xFFFFFFEB`, and `issue_cnt=1`.
- **Wrap arithmetic.** Sending 0x7FFFFFFF×2 → `0xFFFFFFFE`. Sending 0x80000000×0xFFFFFFFF → `0x80000000`.
- **Fairness.** All four requesters hold `valid` for 8 cycles with `rsp_ready=1` → grants are 0,1,2,3,0,1,2,3, `rsp_id` follows one cycle later, and `issue_cnt=8`.
- **Backpressure.** `rsp_ready=0` for 3 cycles while results are pending → `rsp_data`/`rsp_id` are held, `req_ready=0` throughout, no results are lost, and order is preserved after release.
- **Reset mid-flight.** Assert `reset=0` one cycle after a transfer → `rsp_valid` drops immediately and nothing appears after release. `issue_cnt=0` and `ptr=0`, so requester 0 is granted first.
- **Sparse requests.** Only requester 2 is valid, then requesters 0 and 3 → grants go 2, then 3 (first valid from `ptr=3`), then 0.
